// File: rtl/pool2d_stream.sv
// pool2d_stream: streaming non-overlapping POOLxPOOL max/average pooling engine.
// A feature-map frame arrives as CHANNELS raster-ordered planes. One row of
// partial accumulators (one per output column) is kept instead of a frame buffer.
// Ports:
//   clk, reset (sync, active-low)
//   enable             - run permission; low blocks input acceptance
//   mode               - 0 = max, 1 = average; latched on the first beat of a frame
//   in_data/in_valid/in_ready    - input sample stream
//   out_data/out_valid/out_ready - pooled output stream, single-entry register
//   out_last           - marks the final pooled value of the frame
//   busy               - frame in progress
//   frame_done         - one-cycle strobe after the final output transfer
module pool2d_stream #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IN_WIDTH   = 62,
  parameter int unsigned IN_HEIGHT  = 62,
  parameter int unsigned CHANNELS   = 30,
  parameter int unsigned POOL       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned LOG2P = $clog2(POOL);
  localparam int unsigned SHIFT = 2 * LOG2P;
  localparam int unsigned ACC_W = DATA_WIDTH + SHIFT;
  localparam int unsigned OUT_W = IN_WIDTH / POOL;
  localparam int unsigned OUT_H = IN_HEIGHT / POOL;
  localparam int unsigned COL_W = $clog2(IN_WIDTH + 1);
  localparam int unsigned ROW_W = $clog2(IN_HEIGHT + 1);
  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t state, state_nx;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [CH_W-1:0]  ch;
  logic             mode_q;

  logic signed [ACC_W-1:0] acc [OUT_W];

  logic                    xfer_in, xfer_out;
  logic                    last_beat, last_window, in_win;
  logic                    first_beat, end_beat, beat_mode;
  logic [LOG2P-1:0]        col_ph, row_ph;
  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] sample_ext, acc_cur, combined, avg_val;
  logic [DATA_WIDTH-1:0]   pooled;

  // Handshake; in_ready is held low while reset is asserted.
  assign in_ready = reset && enable && (state == IDLE || state == RUN) &&
                    (!out_valid || out_ready);
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

  // Position decode for the current beat.
  assign last_beat   = (ch == CH_W'(CHANNELS - 1)) && (row == ROW_W'(IN_HEIGHT - 1)) &&
                       (col == COL_W'(IN_WIDTH - 1));
  assign in_win      = (col < COL_W'(OUT_W * POOL)) && (row < ROW_W'(OUT_H * POOL));
  assign last_window = (ch == CH_W'(CHANNELS - 1)) && (row == ROW_W'(OUT_H * POOL - 1)) &&
                       (col == COL_W'(OUT_W * POOL - 1));
  assign col_ph      = col[LOG2P-1:0];
  assign row_ph      = row[LOG2P-1:0];
  assign first_beat  = (col_ph == '0) && (row_ph == '0);
  assign end_beat    = (&col_ph) && (&row_ph);
  // The first beat of a frame uses the live mode; later beats use the latched one.
  assign beat_mode   = (state == IDLE) ? mode : mode_q;
  assign sample_ext  = {{SHIFT{in_data[DATA_WIDTH-1]}}, in_data};

  // Accumulator index, clamped for discarded beats so the read stays in range.
  always_comb begin
    idx = '0;
    if (in_win) idx = IDX_W'(col >> LOG2P);
  end

  assign acc_cur = acc[idx];

  // Window combine and final pooled value.
  always_comb begin
    combined = sample_ext;
    if (!first_beat) begin
      if (beat_mode) combined = acc_cur + sample_ext;
      else           combined = (sample_ext > acc_cur) ? sample_ext : acc_cur;
    end
    avg_val = combined >>> SHIFT;
    pooled  = beat_mode ? DATA_WIDTH'(avg_val) : DATA_WIDTH'(combined);
  end

  // Accumulator row; contents need no reset since each window starts with a load.
  always_ff @(posedge clk) begin
    if (xfer_in && in_win) acc[idx] <= combined;
  end

  // Counters, mode latch and output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col       <= '0;
      row       <= '0;
      ch        <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (xfer_out) out_valid <= 1'b0;
      if (xfer_in) begin
        if (state == IDLE) mode_q <= mode;
        if (col == COL_W'(IN_WIDTH - 1)) begin
          col <= '0;
          if (row == ROW_W'(IN_HEIGHT - 1)) begin
            row <= '0;
            ch  <= (ch == CH_W'(CHANNELS - 1)) ? '0 : ch + CH_W'(1);
          end else begin
            row <= row + ROW_W'(1);
          end
        end else begin
          col <= col + COL_W'(1);
        end
        if (in_win && end_beat) begin
          out_valid <= 1'b1;
          out_data  <= pooled;
          out_last  <= last_window;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state. In FLUSH an empty output register means the last value
  // already left before the trailing discarded beats.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (xfer_in) state_nx = RUN;
      RUN:   if (xfer_in && last_beat)
               state_nx = (xfer_out && out_last) ? DONE : FLUSH;
      FLUSH: if (!out_valid || (xfer_out && out_last)) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM status outputs.
  always_comb begin
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      RUN, FLUSH: busy = 1'b1;
      DONE:       frame_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pool2d_stream.sv
// Testbench for pool2d_stream: three instances (4x4x1, 5x5x1, 4x4x3, POOL=2)
// driven with ramp and random frames and compared with a window-level model.
module tb_pool2d_stream;

  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [2:0]    en, md, iv, ir, ov, ordy, ol, bz, fd;
  logic [DW-1:0] id [3];
  logic [DW-1:0] od [3];

  int n_checks = 0;
  int n_fail   = 0;
  int stim[$];
  int expq[$];
  int dim_w [3] = '{4, 5, 4};
  int dim_h [3] = '{4, 5, 4};
  int dim_c [3] = '{1, 1, 3};

  pool2d_stream #(.DATA_WIDTH(16), .IN_WIDTH(4), .IN_HEIGHT(4), .CHANNELS(1), .POOL(2)) u_a (
    .clk(clk), .reset(reset), .enable(en[0]), .mode(md[0]), .in_data(id[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .out_data(od[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_last(ol[0]), .busy(bz[0]), .frame_done(fd[0]));

  pool2d_stream #(.DATA_WIDTH(16), .IN_WIDTH(5), .IN_HEIGHT(5), .CHANNELS(1), .POOL(2)) u_b (
    .clk(clk), .reset(reset), .enable(en[1]), .mode(md[1]), .in_data(id[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .out_data(od[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_last(ol[1]), .busy(bz[1]), .frame_done(fd[1]));

  pool2d_stream #(.DATA_WIDTH(16), .IN_WIDTH(4), .IN_HEIGHT(4), .CHANNELS(3), .POOL(2)) u_c (
    .clk(clk), .reset(reset), .enable(en[2]), .mode(md[2]), .in_data(id[2]),
    .in_valid(iv[2]), .in_ready(ir[2]), .out_data(od[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_last(ol[2]), .busy(bz[2]), .frame_done(fd[2]));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int s16(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  function automatic int floor_div4(input int s);
    int q;
    q = s / 4;
    if ((s % 4 != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: pool each complete 2x2 window of every plane, raster order.
  task automatic build_exp(input int idx, input bit avg);
    int w, h, c, v, s, m;
    w = dim_w[idx]; h = dim_h[idx]; c = dim_c[idx];
    expq.delete();
    for (int ci = 0; ci < c; ci++)
      for (int oy = 0; oy < h / 2; oy++)
        for (int ox = 0; ox < w / 2; ox++) begin
          s = 0;
          m = -(1 << 30);
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              v = s16(stim[ci * h * w + (2 * oy + dy) * w + 2 * ox + dx]);
              s += v;
              if (v > m) m = v;
            end
          expq.push_back((avg ? floor_div4(s) : m) & 32'hFFFF);
        end
  endtask

  task automatic make_ramp(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(i);
  endtask

  task automatic make_rand(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(int'($urandom_range(0, 65535)));
  endtask

  // Synchronous reset for 3 cycles; optionally check every instance's outputs.
  task automatic do_reset(input bit chk);
    @(negedge clk);
    reset = 1'b0;
    iv = '0;
    en = '1;
    ordy = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (chk)
        for (int k = 0; k < 3; k++) begin
          check("rst_out_valid", int'(ov[k]), 0);
          check("rst_out_data", int'(od[k]), 0);
          check("rst_out_last", int'(ol[k]), 0);
          check("rst_busy", int'(bz[k]), 0);
          check("rst_frame_done", int'(fd[k]), 0);
          check("rst_in_ready", int'(ir[k]), 0);
        end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Stream stim[] into instance idx and score outputs against the model.
  // rdy_mode: 0 always ready, 1 one-on/two-off, 2 random (with input bubbles).
  task automatic run_frame(input int idx, input bit avg, input int rdy_mode,
                           input bit toggle_mode, input int pause_at,
                           input bit gap_chk, input int abort_after);
    int n, pos, cyc, outs, last_cyc, e, w, h, cc, rr;
    bit stall, seen_done, held_l, lat_pend;
    int held_d;
    n = stim.size();
    pos = 0; cyc = 0; outs = 0; last_cyc = -100;
    stall = 1'b0; seen_done = 1'b0; held_l = 1'b0; held_d = 0; lat_pend = 1'b0;
    w = dim_w[idx]; h = dim_h[idx];
    build_exp(idx, avg);
    e = expq.size();
    while (!seen_done) begin
      @(negedge clk);
      if (cyc >= 3000) begin
        check("timeout", 0, 1);
        break;
      end
      if (abort_after > 0 && pos >= abort_after) break;
      iv[idx] = (pos < n) && (rdy_mode != 2 || $urandom_range(0, 3) != 0);
      id[idx] = (pos < n) ? 16'(stim[pos]) : '0;
      case (rdy_mode)
        0:       ordy[idx] = 1'b1;
        1:       ordy[idx] = (cyc % 3) == 0;
        default: ordy[idx] = 1'($urandom_range(0, 1));
      endcase
      en[idx] = !(pause_at >= 0 && cyc >= pause_at && cyc < pause_at + 5);
      md[idx] = toggle_mode ? ((pos == 0) ? avg : cyc[0]) : avg;
      #1;
      if (cyc == 0) check("busy_idle", int'(bz[idx]), 0);
      if (pos > 0 && !fd[idx]) check("busy_run", int'(bz[idx]), 1);
      if (lat_pend) check("latency_valid", int'(ov[idx]), 1);
      if (stall) begin
        check("hold_valid", int'(ov[idx]), 1);
        check("hold_data", int'(od[idx]), held_d);
        check("hold_last", int'(ol[idx]), int'(held_l));
      end
      if (ov[idx] && !ordy[idx]) check("stall_in_ready", int'(ir[idx]), 0);
      if (!en[idx]) check("pause_in_ready", int'(ir[idx]), 0);
      if (fd[idx]) begin
        seen_done = 1'b1;
        check("busy_in_done", int'(bz[idx]), 0);
        if (gap_chk) check("done_gap", cyc - last_cyc, 1);
      end
      if (ov[idx] && ordy[idx]) begin
        if (expq.size() == 0) check("extra_output", 1, 0);
        else begin
          e = expq.pop_front();
          check("out_data", int'(od[idx]), e);
          check("out_last", int'(ol[idx]), int'(expq.size() == 0));
        end
        outs++;
        if (ol[idx]) last_cyc = cyc;
      end
      stall = ov[idx] && !ordy[idx];
      held_d = int'(od[idx]);
      held_l = ol[idx];
      lat_pend = 1'b0;
      if (iv[idx] && ir[idx]) begin
        cc = pos % w;
        rr = (pos / w) % h;
        lat_pend = (cc % 2 == 1) && (rr % 2 == 1) && (cc < (w / 2) * 2) && (rr < (h / 2) * 2);
        pos++;
      end
      cyc++;
    end
    @(negedge clk);
    iv[idx] = 1'b0;
    ordy[idx] = 1'b1;
    en[idx] = 1'b1;
    if (abort_after > 0) return;
    #1;
    check("done_one_cycle", int'(fd[idx]), 0);
    check("in_transfers", pos, n);
    check("output_count", outs, dim_c[idx] * (dim_w[idx] / 2) * (dim_h[idx] / 2));
    check("leftover_expected", expq.size(), 0);
  endtask

  initial begin
    reset = 1'b0;
    en = '1; md = '0; iv = '0; ordy = '1;
    for (int k = 0; k < 3; k++) id[k] = '0;

    do_reset(1'b1);

    // Ramp 0..15, max then average.
    make_ramp(16);
    run_frame(0, 1'b0, 0, 1'b0, -1, 1'b1, 0);
    run_frame(0, 1'b1, 0, 1'b0, -1, 1'b1, 0);

    // Negative first window (-1,-2,-3,-4) with random remainder.
    make_rand(16);
    stim[0] = 32'hFFFF; stim[1] = 32'hFFFE; stim[4] = 32'hFFFD; stim[5] = 32'hFFFC;
    run_frame(0, 1'b0, 0, 1'b0, -1, 1'b1, 0);
    run_frame(0, 1'b1, 0, 1'b0, -1, 1'b1, 0);

    // 5x5: last column and row discarded.
    make_ramp(25);
    run_frame(1, 1'b0, 0, 1'b0, -1, 1'b0, 0);

    // 3 channels with 1-on/2-off backpressure.
    make_rand(48);
    run_frame(2, 1'b1, 1, 1'b0, -1, 1'b1, 0);
    run_frame(2, 1'b0, 1, 1'b0, -1, 1'b1, 0);

    // Mode toggled mid-frame plus a 5-cycle enable pause.
    make_rand(48);
    run_frame(2, 1'b0, 0, 1'b1, 10, 1'b1, 0);
    run_frame(2, 1'b1, 0, 1'b1, 20, 1'b1, 0);

    // Reset after 7 beats, then replay the full frame.
    make_rand(16);
    run_frame(0, 1'b1, 0, 1'b0, -1, 1'b0, 7);
    do_reset(1'b1);
    run_frame(0, 1'b1, 0, 1'b0, -1, 1'b1, 0);

    // Random frames with random handshakes.
    for (int t = 0; t < 6; t++) begin
      int k;
      k = int'($urandom_range(0, 2));
      make_rand(dim_w[k] * dim_h[k] * dim_c[k]);
      run_frame(k, 1'($urandom_range(0, 1)), 2, 1'b0, -1, 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pool2d_stream.md
# pool2d_stream

Streaming, parametrised 2D pooling engine that replaces the fixed max-pool stage between `conv2d` and `fully_connected`. It accepts a feature-map stream plane by plane with a valid/ready handshake. It pools non-overlapping POOL×POOL windows in either max or average mode, using a single row of partial accumulators instead of frame storage. It emits one pooled value per window with backpressure, tags the last output of the frame, and pulses a done strobe once the frame is fully drained.

## Interface
- DATA_WIDTH, 16, signed two's-complement sample width (in and out)
- IN_WIDTH, 62, input plane width in samples
- IN_HEIGHT, 62, input plane height in samples
- CHANNELS, 30, number of planes per frame
- POOL, 2, window size and stride; power of two, 2..8, ≤ IN_WIDTH and ≤ IN_HEIGHT

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- enable  in  1  run permission; low pauses acceptance, state held
- mode  in  1  0 = max, 1 = average; sampled on first accepted beat of frame
- in_data  in  DATA_WIDTH  input sample
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts sample this cycle
- out_data  out  DATA_WIDTH  pooled value
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts output
- out_last  out  1  qualifies the final output of the frame
- busy  out  1  frame in progress (RUN or FLUSH)
- frame_done  out  1  one-cycle pulse after the final output transfer

## Operation
- Reset is synchronous, active-low, on port `reset`, clock `clk`.
- Input order per plane is raster, row 0 first, column 0 first. Planes follow each other, channel 0 first.
- Counters: col (0..IN_WIDTH-1), row (0..IN_HEIGHT-1), ch (0..CHANNELS-1). Each advances only on an input transfer (in_valid && in_ready).
- OUT_W = IN_WIDTH/POOL and OUT_H = IN_HEIGHT/POOL, floor division. Columns ≥ OUT_W·POOL and rows ≥ OUT_H·POOL are accepted and discarded, with no accumulator effect.
- Accumulator row buffer: OUT_W entries of ACC_W = DATA_WIDTH + 2·log2(POOL) bits, signed. Index is col/POOL.
- A beat at (row%POOL==0, col%POOL==0) loads the accumulator with the sample, sign-extended. Other in-window beats combine:
  - max mode: signed compare, keep the larger value.
  - avg mode: add.
- A beat at (row%POOL==POOL-1, col%POOL==POOL-1) completes the window and loads the output register:
  - max mode: the max value.
  - avg mode: (sum) >>> 2·log2(POOL), arithmetic shift, i.e. floor. Fits DATA_WIDTH, so no saturation.
- mode is latched in a mode_q register on the first transfer of a frame. Changes to mode mid-frame are ignored.
- FSM:
  - IDLE → RUN on the first input transfer.
  - RUN → FLUSH on the transfer of the last beat (ch=CHANNELS-1, row=IN_HEIGHT-1, col=IN_WIDTH-1).
  - FLUSH → DONE when the out_last output transfers. If that transfer occurs in the same cycle as the RUN→FLUSH transition, skip straight to DONE.
  - DONE → IDLE unconditionally after 1 cycle.
  - frame_done is high exactly in DONE.
- in_ready = enable && state∈{IDLE,RUN} && (!out_valid || out_ready).
- enable low: in_ready low. A pending output may still drain.
- Reset mid-frame: counters, FSM, out_valid, mode_q and the output register clear immediately. Accumulator contents are don't-care, because the first beat of each window overwrites them.

## Timing
- Reset values: in_ready 0 during reset; out_data 0, out_valid 0, out_last 0, busy 0, frame_done 0.
- Latency: out_valid rises the cycle after the window-completing input transfer.
- The output register is single-entry. out_data and out_last are stable while out_valid && !out_ready.
- Throughput: one input per cycle when out_ready is held high. Input and output transfers in the same cycle are legal.
- busy is high from the cycle after the first transfer through the FLUSH state. busy is low in DONE.
- frame_done rises the cycle after the out_last transfer and lasts 1 cycle. The next frame may start the following cycle.

## Test plan
- 4×4, 1 channel, POOL=2, mode=0, input 0..15 → outputs 5, 7, 13, 15. out_last on 15. frame_done 1 cycle after that output transfers.
- Same input with mode=1 → outputs 2, 4, 10, 12. Then one window of −1, −2, −3, −4: max gives −1, avg gives −3 (floor of −2.5).
- 5×5, 1 channel, POOL=2, input 0..24, max → 4 outputs (6, 8, 16, 18). Column 4 and row 4 are discarded. Exactly 25 input transfers.
- 4×4, 3 channels, out_ready toggling 1-on/2-off → 12 outputs in channel order. out_data held while stalled. in_ready low whenever out_valid && !out_ready. Single frame_done pulse.
- Toggle mode mid-frame → all windows pooled with the mode present on the first beat. enable low for 5 cycles mid-frame → no transfers, resumes with correct results.
- Assert reset after 7 beats, then replay the full frame → outputs identical to a clean run. All outputs 0 during reset.
